// File: rtl/cvxif_clmul_unit.sv
// Iterative carry-less multiplier (clmul / clmulh / clmulr) behind a CV-X-IF issue port.
// Consumes BitsPerCycle bits of rs2 per BUSY cycle and returns one result per accepted issue.
module cvxif_clmul_unit #(
    parameter int XLEN         = 32,
    parameter int IdWidth      = 4,
    parameter int BitsPerCycle = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               issue_valid_i,
    output logic               issue_ready_o,
    input  logic [IdWidth-1:0] issue_id_i,
    input  logic [1:0]         issue_op_i,
    input  logic [4:0]         issue_rd_i,
    input  logic [XLEN-1:0]    rs1_i,
    input  logic [XLEN-1:0]    rs2_i,
    output logic               result_valid_o,
    input  logic               result_ready_i,
    output logic [IdWidth-1:0] result_id_o,
    output logic [4:0]         result_rd_o,
    output logic               result_we_o,
    output logic [XLEN-1:0]    result_data_o
);

    localparam int N     = XLEN / BitsPerCycle;
    localparam int StepW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {
        OP_CLMUL   = 2'b00,
        OP_CLMULH  = 2'b01,
        OP_CLMULR  = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_t;

    state_t              state, state_next;
    op_t                 op;
    logic [IdWidth-1:0]  id;
    logic [4:0]          rd;
    logic [2*XLEN-1:0]   a_shift;
    logic [2*XLEN-1:0]   acc;
    logic [2*XLEN-1:0]   acc_next;
    logic [XLEN-1:0]     b_shift;
    logic [StepW-1:0]    step;
    logic [XLEN-1:0]     result_sel;
    logic                accept;
    logic                last_step;

    assign issue_ready_o = (state == IDLE) && !flush_i;
    assign accept        = issue_valid_i && issue_ready_o;
    assign last_step     = (step == StepW'(N - 1));

    // a_shift already carries the step*BitsPerCycle offset, so only the k offset is applied here.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch;
        // blocking '=' is correct here because acc_next is built up sequentially within the loop.
        acc_next = acc;
        for (int k = 0; k < BitsPerCycle; k++) begin
            if (b_shift[k]) begin
                acc_next = acc_next ^ (a_shift << k);
            end
        end
    end

    always_comb begin
        result_sel = '0;
        case (op)
            OP_CLMUL:  result_sel = acc_next[XLEN-1:0];
            OP_CLMULH: result_sel = acc_next[2*XLEN-1:XLEN];
            OP_CLMULR: result_sel = acc_next[2*XLEN-2:XLEN-1];
            default:   result_sel = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (op_t'(issue_op_i) == OP_ILLEGAL) ? DONE : BUSY;
                end
            end
            BUSY:    if (last_step) state_next = DONE;
            DONE:    if (result_ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush_i) begin
            state_next = IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op             <= OP_CLMUL;
            id             <= '0;
            rd             <= '0;
            a_shift        <= '0;
            b_shift        <= '0;
            acc            <= '0;
            step           <= '0;
            result_valid_o <= 1'b0;
            result_we_o    <= 1'b0;
            result_id_o    <= '0;
            result_rd_o    <= '0;
            result_data_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op      <= op_t'(issue_op_i);
                        id      <= issue_id_i;
                        rd      <= issue_rd_i;
                        a_shift <= {{XLEN{1'b0}}, rs1_i};
                        b_shift <= rs2_i;
                        acc     <= '0;
                        step    <= '0;
                        if (op_t'(issue_op_i) == OP_ILLEGAL) begin
                            result_valid_o <= 1'b1;
                            result_we_o    <= 1'b0;
                            result_data_o  <= '0;
                            result_id_o    <= issue_id_i;
                            result_rd_o    <= issue_rd_i;
                        end
                    end
                end
                BUSY: begin
                    acc     <= acc_next;
                    a_shift <= a_shift << BitsPerCycle;
                    b_shift <= b_shift >> BitsPerCycle;
                    step    <= step + 1'b1;
                    if (last_step) begin
                        result_valid_o <= 1'b1;
                        result_we_o    <= 1'b1;
                        result_data_o  <= result_sel;
                        result_id_o    <= id;
                        result_rd_o    <= rd;
                    end
                end
                DONE: begin
                    if (result_ready_i) begin
                        result_valid_o <= 1'b0;
                        result_data_o  <= '0;
                    end
                end
                default: ;
            endcase
            // Flush discards whatever is pending, including a result completing this cycle.
            if (flush_i) begin
                result_valid_o <= 1'b0;
                result_data_o  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cvxif_clmul_unit.sv
// Self-checking bench for cvxif_clmul_unit: a cycle-count behavioural model plus directed literal checks.
// The model derives results from a full-width carry-less product, independent of the iterative datapath.
module tb_cvxif_clmul_unit;

    localparam int XLEN = 32;
    localparam int IW   = 4;
    localparam int BPC  = 4;
    localparam int N    = XLEN / BPC;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            flush_i = 1'b0;
    logic            issue_valid_i = 1'b0;
    logic            issue_ready_o;
    logic [IW-1:0]   issue_id_i = '0;
    logic [1:0]      issue_op_i = '0;
    logic [4:0]      issue_rd_i = '0;
    logic [XLEN-1:0] rs1_i = '0;
    logic [XLEN-1:0] rs2_i = '0;
    logic            result_valid_o;
    logic            result_ready_i = 1'b0;
    logic [IW-1:0]   result_id_o;
    logic [4:0]      result_rd_o;
    logic            result_we_o;
    logic [XLEN-1:0] result_data_o;

    cvxif_clmul_unit #(.XLEN(XLEN), .IdWidth(IW), .BitsPerCycle(BPC)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .issue_valid_i  (issue_valid_i),
        .issue_ready_o  (issue_ready_o),
        .issue_id_i     (issue_id_i),
        .issue_op_i     (issue_op_i),
        .issue_rd_i     (issue_rd_i),
        .rs1_i          (rs1_i),
        .rs2_i          (rs2_i),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .result_id_o    (result_id_o),
        .result_rd_o    (result_rd_o),
        .result_we_o    (result_we_o),
        .result_data_o  (result_data_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Full 64-bit carry-less product, then the op-specific window.
    function automatic logic [31:0] ref_clmul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = '0;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) p = p ^ ({32'b0, a} << i);
        end
        case (op)
            2'b00:   return p[31:0];
            2'b01:   return p[63:32];
            2'b10:   return p[62:31];
            default: return 32'h0;
        endcase
    endfunction

    // Behavioural model: busy flag plus a countdown to result availability.
    logic          m_busy, m_valid;
    int            m_cnt;
    logic [31:0]   m_data;
    logic [IW-1:0] m_id;
    logic [4:0]    m_rd;
    logic          m_we;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_cnt   <= 0;
        end else if (flush_i) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_cnt   <= 0;
        end else if (!m_busy) begin
            if (issue_valid_i) begin
                m_busy <= 1'b1;
                m_id   <= issue_id_i;
                m_rd   <= issue_rd_i;
                m_we   <= (issue_op_i != 2'b11);
                m_data <= ref_clmul(issue_op_i, rs1_i, rs2_i);
                if (issue_op_i == 2'b11) begin
                    m_valid <= 1'b1;
                    m_cnt   <= 0;
                end else begin
                    m_cnt <= N;
                end
            end
        end else if (m_valid) begin
            if (result_ready_i) begin
                m_busy  <= 1'b0;
                m_valid <= 1'b0;
            end
        end else begin
            if (m_cnt == 1) m_valid <= 1'b1;
            m_cnt <= m_cnt - 1;
        end
    end

    always @(negedge clk_i) begin
        if (rst_ni) begin
            check("m_issue_ready", issue_ready_o, !m_busy && !flush_i);
            check("m_result_valid", result_valid_o, m_valid);
            if (m_valid) begin
                check("m_data", result_data_o, m_data);
                check("m_id", result_id_o, m_id);
                check("m_rd", result_rd_o, m_rd);
                check("m_we", result_we_o, m_we);
            end
        end
    end

    task automatic do_issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [IW-1:0] id, input logic [4:0] rd);
        issue_valid_i = 1'b1;
        issue_op_i    = op;
        rs1_i         = a;
        rs2_i         = b;
        issue_id_i    = id;
        issue_rd_i    = rd;
        @(posedge clk_i); #1;
        issue_valid_i = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!result_valid_o && lat < 64) begin
            @(posedge clk_i); #1;
            lat++;
        end
        if (!result_valid_o) check("wait_timeout", result_valid_o, 1'b1);
    endtask

    task automatic take(output logic [31:0] d, output logic [IW-1:0] id, output logic [4:0] rd, output logic we);
        d  = result_data_o;
        id = result_id_o;
        rd = result_rd_o;
        we = result_we_o;
        result_ready_i = 1'b1;
        @(posedge clk_i); #1;
        result_ready_i = 1'b0;
    endtask

    task automatic run(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [IW-1:0] id, input logic [4:0] rd, input logic [31:0] exp, input int exp_lat);
        int            lat;
        logic [31:0]   d;
        logic [IW-1:0] gid;
        logic [4:0]    grd;
        logic          gwe;
        do_issue(op, a, b, id, rd);
        wait_valid(lat);
        check({name, "_lat"}, lat, exp_lat);
        take(d, gid, grd, gwe);
        check({name, "_data"}, d, exp);
        check({name, "_id"}, gid, id);
        check({name, "_rd"}, grd, rd);
        check({name, "_we"}, gwe, op != 2'b11);
    endtask

    initial begin
        int            lat;
        logic [31:0]   d0;
        logic [IW-1:0] id0;
        logic [4:0]    rd0;
        logic          we0;

        // Pin the reference model against hand-computed products.
        check("ref_3x3", ref_clmul(2'b00, 32'd3, 32'd3), 32'h5);
        check("ref_r_msb", ref_clmul(2'b10, 32'h8000_0000, 32'h8000_0000), 32'h8000_0000);
        check("ref_h_ones", ref_clmul(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'h5555_5555);

        repeat (2) @(posedge clk_i);
        #1;
        check("rst_valid", result_valid_o, 1'b0);
        check("rst_data", result_data_o, 32'h0);
        check("rst_id", result_id_o, 4'h0);
        check("rst_rd", result_rd_o, 5'h0);
        check("rst_we", result_we_o, 1'b0);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        check("post_rst_ready", issue_ready_o, 1'b1);

        run("clmul_3x3", 2'b00, 32'd3, 32'd3, 4'd5, 5'd7, 32'h0000_0005, N + 1);
        run("clmul_msb", 2'b00, 32'h8000_0000, 32'h8000_0000, 4'd1, 5'd1, 32'h0000_0000, N + 1);
        run("clmulh_msb", 2'b01, 32'h8000_0000, 32'h8000_0000, 4'd2, 5'd2, 32'h4000_0000, N + 1);
        run("clmulr_msb", 2'b10, 32'h8000_0000, 32'h8000_0000, 4'd3, 5'd3, 32'h8000_0000, N + 1);
        run("clmul_ones", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd4, 5'd4, 32'h5555_5555, N + 1);
        run("clmulh_ones", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd6, 5'd6, 32'h5555_5555, N + 1);

        // Illegal op, held under back-pressure while extra issues are offered.
        do_issue(2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 4'd9, 5'd3);
        wait_valid(lat);
        check("illegal_lat", lat, 1);
        check("illegal_we", result_we_o, 1'b0);
        check("illegal_data", result_data_o, 32'h0);
        d0 = result_data_o; id0 = result_id_o; rd0 = result_rd_o; we0 = result_we_o;
        issue_valid_i = 1'b1;
        issue_op_i    = 2'b00;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i); #1;
            check("hold_valid", result_valid_o, 1'b1);
            check("hold_data", result_data_o, d0);
            check("hold_id", result_id_o, id0);
            check("hold_rd", result_rd_o, rd0);
            check("hold_we", result_we_o, we0);
            check("hold_ready", issue_ready_o, 1'b0);
        end
        issue_valid_i = 1'b0;
        take(d0, id0, rd0, we0);
        check("illegal_id", id0, 4'd9);

        // Flush in BUSY cycle 4 together with a new issue.
        do_issue(2'b00, 32'h0000_00FF, 32'h0000_00FF, 4'd10, 5'd10);
        repeat (3) @(posedge clk_i);
        #1;
        flush_i       = 1'b1;
        issue_valid_i = 1'b1;
        #1;
        check("flush_ready", issue_ready_o, 1'b0);
        @(posedge clk_i); #1;
        flush_i       = 1'b0;
        issue_valid_i = 1'b0;
        #1;
        check("after_flush_ready", issue_ready_o, 1'b1);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk_i); #1;
            check("flush_no_result", result_valid_o, 1'b0);
        end
        run("clmul_6x3", 2'b00, 32'd6, 32'd3, 4'd11, 5'd12, 32'h0000_000A, N + 1);

        // Reset asserted while a result waits in DONE.
        do_issue(2'b00, 32'd5, 32'd7, 4'd13, 5'd13);
        wait_valid(lat);
        check("pre_rst_valid", result_valid_o, 1'b1);
        rst_ni = 1'b0;
        #1;
        check("midrst_valid", result_valid_o, 1'b0);
        check("midrst_data", result_data_o, 32'h0);
        check("midrst_id", result_id_o, 4'h0);
        check("midrst_rd", result_rd_o, 5'h0);
        check("midrst_we", result_we_o, 1'b0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        result_ready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_i); #1;
            check("post_rst_no_result", result_valid_o, 1'b0);
        end
        result_ready_i = 1'b0;

        // Random traffic, back-pressure and flushes; the model process does the checking.
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk_i); #1;
            issue_valid_i  = $urandom_range(0, 1) == 1;
            issue_op_i     = 2'($urandom_range(0, 3));
            rs1_i          = $urandom;
            rs2_i          = $urandom;
            issue_id_i     = 4'($urandom_range(0, 15));
            issue_rd_i     = 5'($urandom_range(0, 31));
            result_ready_i = $urandom_range(0, 2) != 0;
            flush_i        = $urandom_range(0, 19) == 0;
        end
        @(posedge clk_i); #1;
        issue_valid_i  = 1'b0;
        result_ready_i = 1'b0;
        flush_i        = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cvxif_clmul_unit.md
Name: cvxif_clmul_unit

Overview:
Iterative carry-less multiply unit that sits directly downstream of the core's CV-X-IF issue interface. It executes clmul, clmulh and clmulr on XLEN-bit operands and returns one result per accepted instruction through a valid/ready result channel. The unit processes BitsPerCycle bits of rs2 per cycle, which keeps FPGA area low for the 32-bit crypto configuration.

Parameters:
XLEN, 32, operand/result width; must be a multiple of BitsPerCycle.
IdWidth, 4, width of the instruction id tag echoed on the result.
BitsPerCycle, 4, rs2 bits consumed per BUSY cycle; N = XLEN/BitsPerCycle.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  kill any in-flight or pending operation
issue_valid_i  in  1  issue request valid
issue_ready_o  out  1  unit can accept an issue
issue_id_i  in  IdWidth  instruction id
issue_op_i  in  2  00 clmul, 01 clmulh, 10 clmulr, 11 illegal
issue_rd_i  in  5  destination register
rs1_i  in  XLEN  operand a
rs2_i  in  XLEN  operand b
result_valid_o  out  1  result valid
result_ready_i  in  1  result consumed
result_id_o  out  IdWidth  id of the completed instruction
result_rd_o  out  5  destination register
result_we_o  out  1  write-back enable (0 for illegal op)
result_data_o  out  XLEN  result value

Behaviour:
- One clock (clk_i). Reset is asynchronous and active-low (rst_ni). Reset values: state IDLE; result_valid_o, result_we_o, result_id_o, result_rd_o and result_data_o all 0; accumulator 0.
- issue_ready_o = (state==IDLE) && !flush_i. It is therefore 1 out of reset when flush_i is low.
- States:
  - IDLE: on issue_valid_i && issue_ready_o, latch id, rd, op, rs1 and rs2, clear the 2*XLEN accumulator and clear the step counter. A legal op goes to BUSY. op 11 goes to DONE with we=0 and data=0.
  - BUSY: each cycle, for each of the BitsPerCycle low bits b[k] of the rs2 shift register, XOR (rs1 << (step*BitsPerCycle+k)) into the accumulator when b[k]=1. Then shift rs2 right by BitsPerCycle and increment step. After N cycles go to DONE and register the result select:
    - clmul: acc[XLEN-1:0]
    - clmulh: acc[2XLEN-1:XLEN]
    - clmulr: acc[2XLEN-2:XLEN-1]
  - DONE: result_valid_o=1, with data, id, rd and we held stable until result_ready_i. On the handshake go to IDLE, drop result_valid_o and zero result_data_o.
- Latency for an issue accepted at the edge ending cycle T:
  - Legal op: result_valid_o high from cycle T+N+1 (T+9 at the defaults).
  - Illegal op: result_valid_o high from cycle T+1.
- No back-to-back issue: the next issue is accepted no earlier than the cycle after the result handshake.
- flush_i: in any state, the next state is IDLE. result_valid_o is 0 from the next cycle, and the pending result is discarded without a handshake.
  - flush_i blocks a simultaneous issue, because issue_ready_o is 0.
  - If flush_i and result_ready_i coincide in DONE, the outcome is IDLE and the result counts as consumed.
- Reset mid-operation: returns immediately to the reset values, and no stale result may appear after reset release.
- issue_valid_i while not ready is ignored. The unit holds no queue.

Test Plan:
- Reset, then flush_i=0: issue_ready_o=1 and result_valid_o=0 → issue clmul rs1=3, rs2=3, id=5, rd=7 → result_valid_o rises exactly 9 cycles later with data=0x00000005, id=5, rd=7, we=1.
- clmul, clmulh and clmulr with rs1=rs2=0x80000000 → data 0x00000000, 0x40000000 and 0x80000000 respectively.
- clmul and clmulh with rs1=rs2=0xFFFFFFFF → 0x55555555 for both.
- op=11 issue → result_valid_o high the next cycle with we=0 and data=0. Hold result_ready_i=0 for 5 cycles → all result outputs stay stable and issue_ready_o=0 throughout.
- Assert flush_i in BUSY cycle 4, together with issue_valid_i → no result is produced, issue_ready_o=0 during flush and 1 the cycle after. A new clmul 6×3 then returns 0x0000000A.
- Assert rst_ni low for 1 cycle in DONE → outputs are zero immediately and no result appears after release. Random ops against a reference model, with random result_ready_i back-pressure and flushes, produce matching results and ids.
